dm_resp: RTL and testbench

//  Data-memory responder: the memory end of the dm_adr address path.

---
 rtl/dm_resp_if.sv | 25 ++
 rtl/dm_resp.sv | 145 ++++++++++++++
 tb/tb_dm_resp.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_resp_if.sv
// Request/response bundle between a load/store requester and the dm_resp data-memory responder.
// The master issues requests and the slave returns one response pulse per accepted request.
interface dm_resp_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] dm_adr;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, dm_adr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, dm_adr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dm_resp.sv
// Data-memory responder: serves load/store requests against an internal 2^AW x DW array that is
// swept to zero after every reset. The all-ones address is a null address and is never accessed.
module dm_resp #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter logic [2:0]  LdmOp  = 3'b001,
  parameter logic [2:0]  StrOp  = 3'b010
) (
  input  logic       CLK,
  input  logic       reset,
  dm_resp_if.slave   bus,
  output logic       init_done
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned LW    = $clog2(RD_LAT + 1);
  localparam logic [LW-1:0] LatInit = LW'(RD_LAT - 1);
  localparam logic [AW-1:0] NullAdr = {AW{1'b1}};

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("dm_resp: RD_LAT must be in 1..3");
  end

  typedef enum logic [1:0] {StInit, StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   clr_ptr_q, clr_ptr_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [AW-1:0] ld_adr_q, ld_adr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          init_done_q, init_done_d;

  logic [DW-1:0] mem [Depth];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic accept, is_null, is_ld, is_st;

  assign bus.req_ready = (state_q == StIdle);
  assign accept        = bus.req_valid && (state_q == StIdle);
  assign is_null       = (bus.dm_adr == NullAdr);
  assign is_ld         = (bus.req_op == LdmOp);
  assign is_st         = (bus.req_op == StrOp);

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    ld_adr_d    = ld_adr_q;
    init_done_d = init_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q[AW-1:0];
        clr_ptr_d = clr_ptr_q + 1'b1;
        // Carry into the top bit marks the final location of the sweep.
        if (clr_ptr_d[AW]) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end

      StIdle: begin
        if (accept) begin
          if (!is_null && is_st) begin
            mem_we      = 1'b1;
            mem_waddr   = bus.dm_adr;
            mem_wdata   = bus.wr_data;
            rsp_valid_d = 1'b1;
          end else if (!is_null && is_ld) begin
            lat_cnt_d = LatInit;
            ld_adr_d  = bus.dm_adr;
            // Single-cycle loads answer straight from IDLE; longer ones wait out BUSY.
            if (RD_LAT == 1) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = mem[bus.dm_adr];
            end else begin
              state_d = StBusy;
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      StBusy: begin
        lat_cnt_d = lat_cnt_q - LW'(1);
        if (lat_cnt_q == LW'(1)) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem[ld_adr_q];
        end
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      clr_ptr_q   <= '0;
      lat_cnt_q   <= '0;
      ld_adr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      ld_adr_q    <= ld_adr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Array has no reset; the INIT sweep provides the cleared contents.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_dm_resp.sv
// Scoreboard bench: two responders (load latency 1 and 3) share one request stream; a memory
// model predicts each response and its arrival cycle, and a negedge monitor checks both.
module tb_dm_resp;

  localparam logic [2:0] OpLdm = 3'b001;
  localparam logic [2:0] OpStr = 3'b010;
  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 3;

  typedef struct {
    int         due;
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = '0;
  logic [7:0] dm_adr = '0;
  logic [7:0] wr_data = '0;
  logic init_done_a, init_done_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] model_mem [256];
  exp_t q_a[$];
  exp_t q_b[$];

  dm_resp_if #(.AW(8), .DW(8)) bus_a ();
  dm_resp_if #(.AW(8), .DW(8)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_op    = req_op;
  assign bus_a.dm_adr    = dm_adr;
  assign bus_a.wr_data   = wr_data;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_op    = req_op;
  assign bus_b.dm_adr    = dm_adr;
  assign bus_b.wr_data   = wr_data;

  dm_resp #(.AW(8), .DW(8), .RD_LAT(LatA), .LdmOp(OpLdm), .StrOp(OpStr)) u_dut_a (
    .CLK       (CLK),
    .reset     (reset),
    .bus       (bus_a),
    .init_done (init_done_a)
  );

  dm_resp #(.AW(8), .DW(8), .RD_LAT(LatB), .LdmOp(OpLdm), .StrOp(OpStr)) u_dut_b (
    .CLK       (CLK),
    .reset     (reset),
    .bus       (bus_b),
    .init_done (init_done_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one call per responder per negedge.
  task automatic mon(input int which, input logic v, input logic e, input logic [7:0] d);
    exp_t h;
    bit   has;
    has = (which == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (has) h = (which == 0) ? q_a[0] : q_b[0];
    if (v) begin
      if (!has) begin
        chk($sformatf("unexpected_rsp%0d", which), 32'(v), 32'(0));
      end else begin
        if (which == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
        chk($sformatf("rsp_cycle%0d", which), 32'(cyc), 32'(h.due));
        chk($sformatf("rsp_err%0d", which), 32'(e), 32'(h.err));
        chk($sformatf("rsp_data%0d", which), 32'(d), 32'(h.data));
      end
    end else begin
      chk($sformatf("idle_zero%0d", which), {23'd0, e, d}, 32'd0);
      if (has && h.due <= cyc) begin
        chk($sformatf("missing_rsp%0d", which), 32'(v), 32'(1));
        if (which == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      mon(0, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_data);
      mon(1, bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_data);
    end
  end

  // Present one request when both responders are ready; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] adr, input logic [7:0] wd);
    exp_t e;
    int   waited;
    bit   ld_ok;
    waited = 0;
    @(negedge CLK);
    while (!(bus_a.req_ready && bus_b.req_ready)) begin
      waited++;
      if (waited > 20) begin
        n_chk++;
        n_fail++;
        $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
        return;
      end
      @(negedge CLK);
    end
    req_valid = 1'b1;
    req_op    = op;
    dm_adr    = adr;
    wr_data   = wd;
    ld_ok     = (op == OpLdm) && (adr != 8'hFF);
    e.err     = !((op == OpLdm || op == OpStr) && adr != 8'hFF);
    e.data    = ld_ok ? model_mem[adr] : 8'h00;
    e.due     = cyc + (ld_ok ? LatA : 1);
    q_a.push_back(e);
    e.due     = cyc + (ld_ok ? LatB : 1);
    q_b.push_back(e);
    if (op == OpStr && adr != 8'hFF) model_mem[adr] = wd;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  // Release reset on a negedge and check the 256-cycle clear sweep.
  task automatic release_and_check_init();
    @(negedge CLK);
    reset = 1'b0;
    chk("init_ready", {30'd0, bus_a.req_ready, bus_b.req_ready}, 32'd0);
    chk("init_done_low", {30'd0, init_done_a, init_done_b}, 32'd0);
    for (int k = 1; k < 256; k++) begin
      @(negedge CLK);
      chk("init_ready", {30'd0, bus_a.req_ready, bus_b.req_ready}, 32'd0);
      chk("init_done_low", {30'd0, init_done_a, init_done_b}, 32'd0);
    end
    @(negedge CLK);
    chk("init_done_high", {30'd0, init_done_a, init_done_b}, 32'd3);
    chk("idle_ready", {30'd0, bus_a.req_ready, bus_b.req_ready}, 32'd3);
  endtask

  task automatic apply_reset();
    #1;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] adr;
    int         r;
    apply_reset();
    chk("reset_state", {27'd0, bus_a.req_ready, bus_b.req_ready, bus_a.rsp_valid,
                        bus_b.rsp_valid, init_done_a}, 32'd0);
    release_and_check_init();

    issue(OpLdm, 8'h10, 8'h00);
    issue(OpStr, 8'h03, 8'h5A);
    issue(OpLdm, 8'h03, 8'h00);
    issue(OpStr, 8'h04, 8'hA5);
    chk("ready_after_store", {30'd0, bus_a.req_ready, bus_b.req_ready}, 32'd3);
    issue(OpLdm, 8'h04, 8'h00);
    issue(OpStr, 8'hFF, 8'h77);
    issue(OpLdm, 8'hFF, 8'h00);
    issue(OpLdm, 8'hFE, 8'h00);
    issue(3'b101, 8'h05, 8'h33);
    issue(OpLdm, 8'h05, 8'h00);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) op = OpStr;
      else if (r < 8) op = OpLdm;
      else begin
        op = 3'($urandom_range(3, 7));
        if (op == 3'd3) op = 3'd0;
      end
      adr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #1;
      end
      issue(op, adr, 8'($urandom));
    end

    // Reset while the latency-3 load is in flight; its response must never appear.
    issue(OpStr, 8'h03, 8'h5A);
    issue(OpLdm, 8'h03, 8'h00);
    @(posedge CLK);
    apply_reset();
    release_and_check_init();
    issue(OpLdm, 8'h03, 8'h00);
    issue(OpLdm, 8'h04, 8'h00);

    for (int k = 0; k < 20 && (q_a.size() + q_b.size()) != 0; k++) @(posedge CLK);
    @(negedge CLK);
    chk("drain", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule
